// File: rtl/imem_fetch_port.sv
// -----------------------------------------------------------------------------
// imem_fetch_port
// Pipelined instruction memory for the RISC-V core. A word array, written
// through a program-load port, serves byte-addressed fetches over a valid/ready
// request/response handshake. Read data travels through LAT-1 register stages
// into a show-ahead response FIFO that absorbs back-pressure from decode.
// A credit counter (in-flight + buffered) guarantees the FIFO never overflows.
// flush discards every in-flight and buffered fetch on a PC redirect.
//
// Optional feature macro: IMEM_FAULT_EN
//   defined   : misaligned or out-of-range fetches respond in order with
//               rsp_fault = 1 and a NOP (32'h00000013) instead of array data.
//   undefined : req_pc[1:0] ignored, upper PC bits wrap modulo DEPTH,
//               rsp_fault is always 0.
//
// Ports:
//   clk, reset_n            clock (rising edge), async active-low reset
//   req_valid/req_ready     fetch request handshake, req_pc = byte address
//   rsp_valid/rsp_ready     response handshake, rsp_data/rsp_pc/rsp_fault
//   flush                   drop all outstanding fetches
//   ld_en/ld_addr/ld_data   program-load word write
// -----------------------------------------------------------------------------
module imem_fetch_port #(
    parameter int DEPTH     = 256,
    parameter int LAT       = 1,
    parameter int RSP_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_pc,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_data,
    output logic [31:0]              rsp_pc,
    output logic                     rsp_fault,
    input  logic                     flush,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [31:0]              ld_data
);

    localparam int          AW  = $clog2(DEPTH);
    localparam int          CW  = $clog2(RSP_DEPTH + 1);
    localparam int          PW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    // ---------------------------------------------------------------- handshake
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept, pop;

    // A pop in this cycle deliberately does not raise req_ready: the credit is
    // only returned once cnt_q updates, keeping req_ready off the rsp_ready path.
    assign req_ready = (cnt_q < CW'(RSP_DEPTH)) && !flush;
    assign accept    = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;

    // ---------------------------------------------------------------- array
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] rd_idx;
    logic [31:0]   rd_data;
    logic          rd_fault;

    assign rd_idx = req_pc[AW+1:2];

`ifdef IMEM_FAULT_EN
    assign rd_fault = (req_pc[1:0] != 2'b00) || (req_pc[31:AW+2] != '0);
    assign rd_data  = rd_fault ? NOP : mem[rd_idx];
`else
    logic unused_pc_bits;
    assign unused_pc_bits = ^{req_pc[31:AW+2], req_pc[1:0]};
    assign rd_fault       = 1'b0;
    assign rd_data        = mem[rd_idx];
`endif

    // NOTE: the array has no reset; contents are undefined until loaded.
    // Because the read above is combinational and the write lands at the edge,
    // a same-cycle fetch of the written word naturally sees the old value.
    always_ff @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
    end

    // ---------------------------------------------------------------- pipeline
    logic        wr_vld;
    logic [31:0] wr_data, wr_pc;
    logic        wr_fault;

    generate
        if (LAT == 1) begin : g_no_stage
            assign wr_vld   = accept;
            assign wr_data  = rd_data;
            assign wr_pc    = req_pc;
            assign wr_fault = rd_fault;
        end else begin : g_stages
            logic        st_vld_q   [LAT-1];
            logic [31:0] st_data_q  [LAT-1];
            logic [31:0] st_pc_q    [LAT-1];
            logic        st_fault_q [LAT-1];

            // NOTE: sequential state uses non-blocking assignments so every
            // stage samples its predecessor's pre-edge value.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < LAT - 1; i++) st_vld_q[i] <= 1'b0;
                end else if (flush) begin
                    for (int i = 0; i < LAT - 1; i++) st_vld_q[i] <= 1'b0;
                end else begin
                    st_vld_q[0] <= accept;
                    for (int i = 1; i < LAT - 1; i++) st_vld_q[i] <= st_vld_q[i-1];
                end
            end

            // Payload is qualified by the valid bits, so it needs no reset.
            always_ff @(posedge clk) begin
                st_data_q[0]  <= rd_data;
                st_pc_q[0]    <= req_pc;
                st_fault_q[0] <= rd_fault;
                for (int i = 1; i < LAT - 1; i++) begin
                    st_data_q[i]  <= st_data_q[i-1];
                    st_pc_q[i]    <= st_pc_q[i-1];
                    st_fault_q[i] <= st_fault_q[i-1];
                end
            end

            assign wr_vld   = st_vld_q[LAT-2];
            assign wr_data  = st_data_q[LAT-2];
            assign wr_pc    = st_pc_q[LAT-2];
            assign wr_fault = st_fault_q[LAT-2];
        end
    endgenerate

    // ---------------------------------------------------------------- response FIFO
    logic [31:0]   buf_data_q  [RSP_DEPTH];
    logic [31:0]   buf_pc_q    [RSP_DEPTH];
    logic          buf_fault_q [RSP_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] fill_q, fill_d;
    logic          push;

    assign push = wr_vld && !flush;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        cnt_d    = cnt_q;
        fill_d   = fill_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            cnt_d    = '0;
            fill_d   = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (accept && !pop) cnt_d = cnt_q + 1'b1;
            if (!accept && pop) cnt_d = cnt_q - 1'b1;
            if (push && !pop)   fill_d = fill_q + 1'b1;
            if (!push && pop)   fill_d = fill_q - 1'b1;
            if (push)           wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            fill_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            fill_q   <= fill_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_data_q[wr_ptr_q]  <= wr_data;
            buf_pc_q[wr_ptr_q]    <= wr_pc;
            buf_fault_q[wr_ptr_q] <= wr_fault;
        end
    end

    // Fields are forced to zero while empty so reset and flush present clean
    // outputs without resetting the entry storage.
    assign rsp_valid = (fill_q != '0);
    assign rsp_data  = rsp_valid ? buf_data_q[rd_ptr_q]  : '0;
    assign rsp_pc    = rsp_valid ? buf_pc_q[rd_ptr_q]    : '0;
    assign rsp_fault = rsp_valid ? buf_fault_q[rd_ptr_q] : 1'b0;

endmodule

// File: tb/tb_imem_fetch_port.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch_port
// Directed bench for imem_fetch_port. Two instances share clock, reset and the
// load port: dut_a (LAT=1, RSP_DEPTH=2) and dut_b (LAT=2, RSP_DEPTH=3).
// Inputs change 1 time unit after the rising edge; outputs are sampled one
// further unit later, well away from the edge.
// -----------------------------------------------------------------------------
module tb_imem_fetch_port;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;

    logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_fault, a_flush;
    logic [31:0] a_req_pc, a_rsp_data, a_rsp_pc;
    logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_fault, b_flush;
    logic [31:0] b_req_pc, b_rsp_data, b_rsp_pc;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_m [8];
    logic [31:0] exp_d6, exp_d400;
    logic        exp_f6, exp_f400;

    always #5 clk = ~clk;

    imem_fetch_port #(.DEPTH(256), .LAT(1), .RSP_DEPTH(2)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_pc(a_req_pc),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data),
        .rsp_pc(a_rsp_pc), .rsp_fault(a_rsp_fault), .flush(a_flush),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    imem_fetch_port #(.DEPTH(256), .LAT(2), .RSP_DEPTH(3)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_pc(b_req_pc),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
        .rsp_pc(b_rsp_pc), .rsp_fault(b_rsp_fault), .flush(b_flush),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        mem_m[0] = 32'h0041_1083;
        mem_m[1] = 32'h0032_2423;
        for (int i = 2; i < 8; i++) mem_m[i] = 32'hA000_0000 | 32'(i);

        reset_n = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        a_req_valid = 1'b0; a_req_pc = '0; a_rsp_ready = 1'b0; a_flush = 1'b0;
        b_req_valid = 1'b0; b_req_pc = '0; b_rsp_ready = 1'b0; b_flush = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
        #1;

        // ---- reset state
        check("rst_a_rsp_valid", 32'(a_rsp_valid), 32'd0);
        check("rst_a_rsp_data",  a_rsp_data, 32'd0);
        check("rst_a_rsp_pc",    a_rsp_pc,   32'd0);
        check("rst_a_rsp_fault", 32'(a_rsp_fault), 32'd0);
        check("rst_a_req_ready", 32'(a_req_ready), 32'd1);
        check("rst_b_rsp_valid", 32'(b_rsp_valid), 32'd0);
        check("rst_b_req_ready", 32'(b_req_ready), 32'd1);

        // ---- program load, indices 0..7
        for (int i = 0; i < 8; i++) begin
            ld_en = 1'b1; ld_addr = 8'(i); ld_data = mem_m[i];
            step();
        end
        ld_en = 1'b0;

        // ---- back-to-back fetch, LAT=1
        a_rsp_ready = 1'b1;
        a_req_valid = 1'b1; a_req_pc = 32'd0;
        #1;
        check("b2b_ready0", 32'(a_req_ready), 32'd1);
        check("b2b_empty0", 32'(a_rsp_valid), 32'd0);
        step();
        a_req_pc = 32'd4;
        #1;
        check("b2b_valid0", 32'(a_rsp_valid), 32'd1);
        check("b2b_data0",  a_rsp_data, 32'h0041_1083);
        check("b2b_pc0",    a_rsp_pc,   32'd0);
        check("b2b_ready1", 32'(a_req_ready), 32'd1);
        step();
        a_req_valid = 1'b0;
        #1;
        check("b2b_valid1", 32'(a_rsp_valid), 32'd1);
        check("b2b_data1",  a_rsp_data, 32'h0032_2423);
        check("b2b_pc1",    a_rsp_pc,   32'd4);
        step();
        check("b2b_drained", 32'(a_rsp_valid), 32'd0);

        // ---- back-pressure, LAT=2 RSP_DEPTH=3
        b_rsp_ready = 1'b0;
        b_req_valid = 1'b1;
        for (int c = 0, k = 0; c < 6; c++) begin
            b_req_pc = 32'(4 * k);
            #1;
            check($sformatf("bp_ready_c%0d", c), 32'(b_req_ready), (c < 3) ? 32'd1 : 32'd0);
            if (c < 3) k++;
            step();
        end
        b_req_valid = 1'b0;
        check("bp_head_valid", 32'(b_rsp_valid), 32'd1);
        check("bp_head_pc",    b_rsp_pc,   32'd0);
        step();
        check("bp_hold_pc",    b_rsp_pc,   32'd0);
        check("bp_hold_data",  b_rsp_data, mem_m[0]);
        b_rsp_ready = 1'b1;
        #1;
        check("bp_pop_no_ready", 32'(b_req_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_drain_valid%0d", i), 32'(b_rsp_valid), 32'd1);
            check($sformatf("bp_drain_pc%0d", i),    b_rsp_pc,   32'(4 * i));
            check($sformatf("bp_drain_data%0d", i),  b_rsp_data, mem_m[i]);
            step();
        end
        check("bp_drained", 32'(b_rsp_valid), 32'd0);
        check("bp_ready_back", 32'(b_req_ready), 32'd1);

        // ---- flush, LAT=2
        b_rsp_ready = 1'b0;
        b_req_valid = 1'b1; b_req_pc = 32'd8;
        step();
        b_req_pc = 32'd12;
        step();
        b_req_valid = 1'b0; b_flush = 1'b1;
        #1;
        check("fl_ready_in_f", 32'(b_req_ready), 32'd0);
        step();
        b_flush = 1'b0; b_rsp_ready = 1'b1;
        b_req_valid = 1'b1; b_req_pc = 32'd16;
        #1;
        check("fl_valid_f1", 32'(b_rsp_valid), 32'd0);
        check("fl_ready_f1", 32'(b_req_ready), 32'd1);
        step();
        b_req_valid = 1'b0;
        check("fl_valid_f2", 32'(b_rsp_valid), 32'd0);
        step();
        check("fl_new_valid", 32'(b_rsp_valid), 32'd1);
        check("fl_new_pc",    b_rsp_pc,   32'd16);
        check("fl_new_data",  b_rsp_data, mem_m[4]);
        step();
        check("fl_no_stale", 32'(b_rsp_valid), 32'd0);

        // ---- load/fetch collision, LAT=1
        a_rsp_ready = 1'b1;
        ld_en = 1'b1; ld_addr = 8'd2; ld_data = 32'hDEAD_BEEF;
        a_req_valid = 1'b1; a_req_pc = 32'd8;
        step();
        ld_en = 1'b0;
        #1;
        check("col_old_data", a_rsp_data, mem_m[2]);
        mem_m[2] = 32'hDEAD_BEEF;
        step();
        a_req_valid = 1'b0;
        check("col_new_data", a_rsp_data, 32'hDEAD_BEEF);
        step();

        // ---- fault behaviour, LAT=1
`ifdef IMEM_FAULT_EN
        exp_d6 = 32'h0000_0013;  exp_f6 = 1'b1;
        exp_d400 = 32'h0000_0013; exp_f400 = 1'b1;
`else
        exp_d6 = mem_m[1];  exp_f6 = 1'b0;
        exp_d400 = mem_m[0]; exp_f400 = 1'b0;
`endif
        a_req_valid = 1'b1; a_req_pc = 32'h6;
        step();
        a_req_pc = 32'h400;
        #1;
        check("flt6_pc",    a_rsp_pc, 32'h6);
        check("flt6_data",  a_rsp_data, exp_d6);
        check("flt6_fault", 32'(a_rsp_fault), 32'(exp_f6));
        step();
        a_req_valid = 1'b0;
        check("flt400_pc",    a_rsp_pc, 32'h400);
        check("flt400_data",  a_rsp_data, exp_d400);
        check("flt400_fault", 32'(a_rsp_fault), 32'(exp_f400));
        step();

        // ---- reset mid-stream, LAT=2
        b_rsp_ready = 1'b0;
        b_req_valid = 1'b1; b_req_pc = 32'd0;
        step();
        b_req_pc = 32'd4;
        step();
        b_req_valid = 1'b0;
        #1;
        check("mrst_pre_valid", 32'(b_rsp_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mrst_valid_now", 32'(b_rsp_valid), 32'd0);
        check("mrst_data_now",  b_rsp_data, 32'd0);
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("mrst_stale%0d", i), 32'(b_rsp_valid), 32'd0);
            check($sformatf("mrst_ready%0d", i), 32'(b_req_ready), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
